flash_burst_ctrl: RTL

// - Initiator for the 24-bit/8-bit flash array port (we/re/addr/in/out): turns one host burst

---
 rtl/flash_pkg.sv | 19 +
 rtl/flash_rd_fifo.sv | 57 +++++
 rtl/flash_burst_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// flash_pkg: shared widths and the burst controller state encoding.
//   FLASH_AW    flash byte-address width (4-bit block field above a 20-bit offset)
//   FLASH_DW    flash data width
//   FLASH_BLK_W block field width at the top of the address
//   fb_state_t  controller states
package flash_pkg;

  localparam int unsigned FLASH_AW    = 24;
  localparam int unsigned FLASH_DW    = 8;
  localparam int unsigned FLASH_BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DRAIN
  } fb_state_t;

endpackage

// File: rtl/flash_rd_fifo.sv
// flash_rd_fifo: small synchronous FIFO holding flash read returns until the host takes them.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write one entry (ignored when full unless a pop happens in the same cycle)
//   pop, dout     remove the head entry (ignored when empty); dout is the current head
//   count         number of stored entries, 0..DEPTH
//   empty, full   status flags
module flash_rd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is still safe.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flash_burst_ctrl.sv
// flash_burst_ctrl: turns one host burst command into single-byte flash reads or writes.
// Optional build macro: FLASH_BURST_STATS_EN adds stat_rd_bytes / stat_wr_bytes.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_len   direction, start address, byte count minus one
//   wr_valid/wr_ready/wr_data      write-data stream into the flash
//   rd_valid/rd_ready/rd_data      read-data stream out of the read FIFO
//   done                           one-cycle pulse at burst completion
//   f_we, f_re, f_addr, f_in       registered flash strobes, address and write data
//   f_out                          flash read data, valid the cycle after f_re
//   stat_rd_bytes, stat_wr_bytes   saturating byte counters (FLASH_BURST_STATS_EN only)
module flash_burst_ctrl
  import flash_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [FLASH_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [FLASH_DW-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [FLASH_DW-1:0] rd_data,
  output logic                done,
  output logic                f_we,
  output logic                f_re,
  output logic [FLASH_AW-1:0] f_addr,
  output logic [FLASH_DW-1:0] f_in,
  input  logic [FLASH_DW-1:0] f_out
`ifdef FLASH_BURST_STATS_EN
  ,
  output logic [31:0]         stat_rd_bytes,
  output logic [31:0]         stat_wr_bytes
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_t           state_q, state_d;
  logic [FLASH_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                pend_q;  // f_out carries a read return this cycle
  logic                f_we_d, f_re_d, done_d;
  logic [FLASH_AW-1:0] f_addr_d;
  logic [FLASH_DW-1:0] f_in_d;

  logic [CW-1:0]       fifo_count;
  logic                fifo_empty, fifo_full, rd_pop, credit;
  logic [CW:0]         credit_sum;

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign rd_valid  = ~fifo_empty;
  assign rd_pop    = rd_valid & rd_ready;

  // Reserve a FIFO slot for every read still travelling through the flash, so a return
  // never arrives without room even if the host stops popping.
  assign credit_sum = {1'b0, fifo_count} + {{CW{1'b0}}, f_re} + {{CW{1'b0}}, pend_q};
  assign credit     = ~fifo_full && (credit_sum < (CW + 1)'(FIFO_DEPTH));

  flash_rd_fifo #(
    .WIDTH(FLASH_DW),
    .DEPTH(FIFO_DEPTH)
  ) u_rd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend_q),
    .din  (f_out),
    .pop  (rd_pop),
    .dout (rd_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    f_we_d   = 1'b0;
    f_re_d   = 1'b0;
    f_addr_d = f_addr;
    f_in_d   = f_in;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = cmd_len;
          if (cmd_write) begin
            state_d = WRITE;
          end else begin
            // First read issues straight from the accept cycle; cnt then holds the
            // number of reads still to issue.
            f_re_d   = 1'b1;
            f_addr_d = cmd_addr;
            addr_d   = cmd_addr + FLASH_AW'(1);
            state_d  = (cmd_len == '0) ? DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (wr_valid) begin
          f_we_d   = 1'b1;
          f_addr_d = addr_q;
          f_in_d   = wr_data;
          addr_d   = addr_q + FLASH_AW'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (credit) begin
          f_re_d   = 1'b1;
          f_addr_d = addr_q;
          addr_d   = addr_q + FLASH_AW'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!f_re && !pend_q && rd_pop && fifo_count == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      f_we    <= 1'b0;
      f_re    <= 1'b0;
      f_addr  <= '0;
      f_in    <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pend_q  <= f_re;
      f_we    <= f_we_d;
      f_re    <= f_re_d;
      f_addr  <= f_addr_d;
      f_in    <= f_in_d;
      done    <= done_d;
    end
  end

`ifdef FLASH_BURST_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_bytes <= '0;
      stat_wr_bytes <= '0;
    end else begin
      if (rd_pop && stat_rd_bytes != '1) stat_rd_bytes <= stat_rd_bytes + 32'd1;
      if (f_we && stat_wr_bytes != '1)   stat_wr_bytes <= stat_wr_bytes + 32'd1;
    end
  end
`endif

endmodule
